// File: rtl/ysyx_22040237_pipe_stage.sv
// rtl/ysyx_22040237_pipe_stage.sv - valid/ready pipeline register with optional skid entry; perf counters under YSYX_22040237_PIPE_PERF_EN
module ysyx_22040237_pipe_stage #(
    parameter int              DATA_W  = 128,
    parameter int              PC_W    = 64,
    parameter bit              SKID_EN = 1'b1,
    parameter logic [PC_W-1:0] RST_PC  = PC_W'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [PC_W-1:0]   in_pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [PC_W-1:0]   out_pc_o
`ifdef YSYX_22040237_PIPE_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [PC_W-1:0]   main_pc_q, skid_pc_q;
    logic              accept, consume;
    logic              load_main, main_from_skid, load_skid;

    assign out_valid_o = (state_q != S_EMPTY);
    assign out_data_o  = main_data_q;
    assign out_pc_o    = main_pc_q;

    // With the skid entry, ready depends only on registered occupancy.
    assign in_ready_o = !rst && (SKID_EN ? (state_q != S_TWO)
                                         : (!out_valid_o || out_ready_i));

    assign accept  = in_valid_i && in_ready_o;
    assign consume = out_valid_o && out_ready_i;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d   = S_ONE;
                        load_main = 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && consume) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = S_TWO;
                        load_skid = 1'b1;
                    end else if (consume) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (consume) begin
                        state_d        = S_ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            main_pc_q   <= RST_PC;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_data_q <= in_data_i;
                main_pc_q   <= in_pc_i;
            end else if (main_from_skid) begin
                main_data_q <= skid_data_q;
                main_pc_q   <= skid_pc_q;
            end
            if (load_skid) begin
                skid_data_q <= in_data_i;
                skid_pc_q   <= in_pc_i;
            end
        end
    end

`ifdef YSYX_22040237_PIPE_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // A flush only counts when it actually throws work away.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid_o && !out_ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_i && (out_valid_o || accept)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22040237_pipe_stage.sv
// tb/tb_ysyx_22040237_pipe_stage.sv - checks skid and non-skid pipe stages against a FIFO model
module tb_ysyx_22040237_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush    [2];
    logic        in_valid [2];
    logic        in_ready [2];
    logic [31:0] in_data  [2];
    logic [63:0] in_pc    [2];
    logic        out_valid[2];
    logic        out_ready[2];
    logic [31:0] out_data [2];
    logic [63:0] out_pc   [2];
`ifdef YSYX_22040237_PIPE_PERF_EN
    logic [31:0] stall_cnt[2];
    logic [31:0] flush_cnt[2];
`endif

    always #5 clk = ~clk;

    ysyx_22040237_pipe_stage #(.DATA_W(32), .PC_W(64), .SKID_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush[0]),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .in_data_i(in_data[0]), .in_pc_i(in_pc[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .out_data_o(out_data[0]), .out_pc_o(out_pc[0])
`ifdef YSYX_22040237_PIPE_PERF_EN
        , .stall_cnt_o(stall_cnt[0]), .flush_cnt_o(flush_cnt[0])
`endif
    );

    ysyx_22040237_pipe_stage #(.DATA_W(32), .PC_W(64), .SKID_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .flush_i(flush[1]),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .in_data_i(in_data[1]), .in_pc_i(in_pc[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .out_data_o(out_data[1]), .out_pc_o(out_pc[1])
`ifdef YSYX_22040237_PIPE_PERF_EN
        , .stall_cnt_o(stall_cnt[1]), .flush_cnt_o(flush_cnt[1])
`endif
    );

    // Reference: a FIFO of {pc,data} with capacity 2 (skid) or 1 (no skid).
    logic [95:0] mem [2][2];
    int          cnt [2];
    logic [95:0] last[2];
    logic [31:0] stall_m[2];
    logic [31:0] flush_m[2];
    int          checks = 0;
    int          fails  = 0;

    task automatic chk(input int k, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    function automatic logic model_ready(input int k);
        if (rst) return 1'b0;
        if (k == 0) return cnt[k] < 2;
        return (cnt[k] == 0) || out_ready[k];
    endfunction

    task automatic drive(input int k, input logic v, input logic [31:0] d);
        in_valid[k] = v;
        in_data[k]  = d;
        in_pc[k]    = 64'h8000_0000 + 64'(d) * 4;
    endtask

    task automatic tick();
        logic [95:0] exp_beat;
        logic        rdy [2];
        logic        acc;
        #1;
        for (int k = 0; k < 2; k++) begin
            rdy[k]   = model_ready(k);
            exp_beat = (cnt[k] > 0) ? mem[k][0] : last[k];
            chk(k, "in_ready", 64'(in_ready[k]), 64'(rdy[k]));
            chk(k, "out_valid", 64'(out_valid[k]), 64'(cnt[k] > 0));
            chk(k, "out_data", 64'(out_data[k]), 64'(exp_beat[31:0]));
            chk(k, "out_pc", out_pc[k], exp_beat[95:32]);
`ifdef YSYX_22040237_PIPE_PERF_EN
            chk(k, "stall_cnt", 64'(stall_cnt[k]), 64'(stall_m[k]));
            chk(k, "flush_cnt", 64'(flush_cnt[k]), 64'(flush_m[k]));
`endif
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            acc = in_valid[k] && rdy[k];
            if (rst) begin
                cnt[k]     = 0;
                last[k]    = {64'h8000_0000, 32'h0};
                stall_m[k] = 0;
                flush_m[k] = 0;
            end else begin
                if (cnt[k] > 0 && !out_ready[k]) stall_m[k] = stall_m[k] + 1;
                if (flush[k]) begin
                    if (cnt[k] > 0 || acc) flush_m[k] = flush_m[k] + 1;
                    cnt[k] = 0;
                end else begin
                    if (cnt[k] > 0 && out_ready[k]) begin
                        mem[k][0] = mem[k][1];
                        cnt[k]--;
                    end
                    if (acc) begin
                        mem[k][cnt[k]] = {in_pc[k], in_data[k]};
                        cnt[k]++;
                    end
                end
                if (cnt[k] > 0) last[k] = mem[k][0];
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            flush[k] = 1'b0; out_ready[k] = 1'b0; drive(k, 1'b0, 32'h0);
            cnt[k] = 0; last[k] = {64'h8000_0000, 32'h0}; stall_m[k] = 0; flush_m[k] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                out_ready[k] = 1'b1;
                drive(k, 1'b1, 32'(i));
            end
            tick();
        end
        for (int k = 0; k < 2; k++) drive(k, 1'b0, 32'h0);
        tick();

        // Back-pressure fills the skid; third beat is refused until space frees
        out_ready[0] = 1'b0;
        drive(0, 1'b1, 32'hA); tick();
        drive(0, 1'b1, 32'hB); tick();
        drive(0, 1'b1, 32'hC); tick(); tick();
        out_ready[0] = 1'b1; tick(); tick();
        drive(0, 1'b0, 32'h0); tick(); tick();

        // Flush while full, with a beat on the input
        out_ready[0] = 1'b0;
        drive(0, 1'b1, 32'h11); tick();
        drive(0, 1'b1, 32'h12); tick();
        drive(0, 1'b1, 32'hD); flush[0] = 1'b1; tick();
        flush[0] = 1'b0; drive(0, 1'b0, 32'h0); tick();
        out_ready[0] = 1'b1; tick(); tick();

        // Reset while full
        out_ready[0] = 1'b0;
        drive(0, 1'b1, 32'h21); tick();
        drive(0, 1'b1, 32'h22); tick();
        drive(0, 1'b0, 32'h0); rst = 1'b1; tick();
        rst = 1'b0; tick();
        out_ready[0] = 1'b1; tick();

        // Random traffic on both variants
        for (int n = 0; n < 200; n++) begin
            for (int k = 0; k < 2; k++) begin
                out_ready[k] = 1'($urandom_range(0, 1));
                flush[k]     = ($urandom_range(0, 15) == 0);
                drive(k, 1'($urandom_range(0, 1)), $urandom);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            flush[k] = 1'b0; drive(k, 1'b0, 32'h0);
        end

`ifdef YSYX_22040237_PIPE_PERF_EN
        // Stall counting, then wrap from all-ones
        out_ready[0] = 1'b1; flush[0] = 1'b1; tick();
        flush[0] = 1'b0; drive(0, 1'b1, 32'h31); tick();
        drive(0, 1'b0, 32'h0); out_ready[0] = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        force dut0.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut0.stall_cnt_q;
        stall_m[0] = 32'hFFFF_FFFF;
        tick();
        tick();
        chk(0, "stall_wrap", 64'(stall_cnt[0]), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_22040237_pipe_stage.md
Name: ysyx_22040237_pipe_stage

Overview:
Parametrised inter-stage pipeline register, used to split the single-cycle datapath (IFU→IDU→EXU→LSU→WBU) into a pipelined core. One instance sits between each pair of adjacent stages. It carries a payload plus the instruction PC over a valid/ready handshake. It supports back-pressure (stall) and a flush from branch/jump redirect, and a 2-entry skid buffer gives full throughput with a registered in_ready_o.

Parameters:
DATA_W, 128, payload width (stage control bus + operands), minimum 1
PC_W, 64, PC field width
SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o
RST_PC, 64'h8000_0000, value of out_pc_o after reset

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous reset, active-high
flush_i  in  1  discard all held entries and the current input beat
in_valid_i  in  1  upstream beat valid
in_ready_o  out  1  stage can accept a beat
in_data_i  in  DATA_W  upstream payload
in_pc_i  in  PC_W  upstream PC
out_valid_o  out  1  downstream beat valid
out_ready_i  in  1  downstream accepts
out_data_o  out  DATA_W  payload to downstream
out_pc_o  out  PC_W  PC to downstream

Behaviour:
- One clock. Reset is synchronous and active-high: clk, rst sampled on the rising edge.
- Reset values: out_valid_o=0, out_data_o=0, out_pc_o=RST_PC, skid empty.
- in_ready_o=0 in any cycle where rst=1. After reset it is 1.
- Transfer rule: input beat accepted iff in_valid_i && in_ready_o. Output beat consumed iff out_valid_o && out_ready_i.
- Payload and PC travel together, unmodified. Latency is exactly 1 cycle from acceptance to out_valid_o when the stage was empty.
- SKID_EN=1 state machine (count of held entries):
  - EMPTY: accept → ONE.
  - ONE: consume without accept → EMPTY. Accept and consume → ONE, main reg loads the new beat. Accept without consume → TWO, beat goes to the skid reg.
  - TWO: consume → ONE, main loads from skid, skid clears. No accept is possible.
  - in_ready_o = !skid_valid (registered, no combinational path from out_ready_i).
- SKID_EN=0:
  - in_ready_o = !out_valid_o || out_ready_i (combinational).
  - States EMPTY/ONE only. Accept and consume in the same cycle → ONE with the new beat.
- Ordering is strict FIFO. No beat is duplicated or dropped except by flush.
- While out_valid_o=1 && out_ready_i=0, out_data_o and out_pc_o stay stable.
- flush_i=1 at an edge:
  - next state is EMPTY; out_valid_o=0 next cycle.
  - a beat accepted in the same cycle is discarded.
  - flush has priority over accept and consume.
  - out_data_o and out_pc_o keep their old values; only valid clears.
- rst has priority over flush_i.
- Reset mid-transfer (TWO state): next cycle EMPTY, outputs return to reset values.
- in_valid_i=1 while in_ready_o=0 is legal: the beat is not taken and the upstream must hold it.

Optional Feature:
Macro YSYX_22040237_PIPE_PERF_EN. When defined, adds two outputs:
- stall_cnt_o [31:0]: +1 every cycle with out_valid_o && !out_ready_i.
- flush_cnt_o [31:0]: +1 every flush that discards at least one valid held entry or in-flight accepted beat.

Both counters reset to 0 and wrap from 0xFFFF_FFFF to 0. When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Reset, then stream 8 beats (data=i, pc=0x8000_0000+4i) with out_ready_i=1 → out beats in the same order, 1-cycle latency, in_ready_o stays 1, one beat per cycle.
2. SKID_EN=1: out_ready_i=0, push 3 beats (0xA, 0xB, 0xC) → 0xA and 0xB held, in_ready_o=0 after the 2nd beat, 0xC not taken. Raise out_ready_i → 0xA, 0xB, 0xC in order, no bubble.
3. Hold state TWO, pulse flush_i with in_valid_i=1 (data 0xD) → next cycle out_valid_o=0, in_ready_o=1. 0xD never appears. flush_cnt_o=1 when the macro is on.
4. rst=1 asserted while in TWO → next cycle out_valid_o=0, out_pc_o=0x8000_0000, out_data_o=0. in_ready_o=0 during rst, 1 afterwards.
5. SKID_EN=0, out_ready_i toggled randomly 200 cycles, random in_valid_i → scoreboard matches, in_ready_o == !out_valid_o || out_ready_i every cycle.
6. Macro on: hold out_ready_i=0 for 5 cycles with out_valid_o=1 → stall_cnt_o=5. Preload 0xFFFF_FFFF via force and stall 1 cycle → wraps to 0.
